// File: rtl/burst_rr_scheduler.sv
// Burst-granular round-robin scheduler for one shared beat-oriented resource.
// A grant holds until last, owner request drop (idle cycle) or MAX_BURST beats.
module burst_rr_scheduler #(
  parameter int PORTS     = 4,
  parameter int MAX_BURST = 8,
  localparam int IDX_W    = $clog2(PORTS),
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PORTS-1:0] i_req_vec,
  input  logic [PORTS-1:0] i_last_vec,
  input  logic             i_beat,
  output logic [PORTS-1:0] o_grant_vec,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic [CNT_W-1:0] o_beat_cnt
);

  localparam int PW = IDX_W + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [PORTS-1:0] r_grant_vec, w_grant_vec_nxt;
  logic [IDX_W-1:0] r_grant_idx, w_grant_idx_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [IDX_W-1:0] w_ptr_inc, w_search_ptr, w_win_idx;
  logic             w_win_found, w_own_req, w_own_last, w_cap, w_term;

  // Circular first-set search starting at 'from'; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] f_rr_search(input logic [PORTS-1:0] req,
                                                  input logic [IDX_W-1:0] from);
    logic [IDX_W:0] pos;
    logic [IDX_W:0] res;
    res = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      pos = {1'b0, from} + PW'(k);
      if (pos >= PW'(PORTS)) pos = pos - PW'(PORTS);
      if (!res[IDX_W] && req[pos[IDX_W-1:0]]) res = {1'b1, pos[IDX_W-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    w_own_req    = i_req_vec[r_grant_idx];
    w_own_last   = i_last_vec[r_grant_idx];
    w_cap        = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    w_term       = (i_beat && (w_own_last || w_cap)) || (!w_own_req && !i_beat);
    w_ptr_inc    = (r_grant_idx == IDX_W'(PORTS - 1)) ? '0 : r_grant_idx + IDX_W'(1);
    // On termination the search already uses the rotated pointer (owner last).
    w_search_ptr = (r_state == S_GRANT) ? w_ptr_inc : r_ptr;
    {w_win_found, w_win_idx} = f_rr_search(i_req_vec, w_search_ptr);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_vec_nxt = r_grant_vec;
    w_grant_idx_nxt = r_grant_idx;
    w_ptr_nxt       = r_ptr;
    w_beat_cnt_nxt  = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt     = S_GRANT;
          w_grant_vec_nxt = PORTS'(1) << w_win_idx;
          w_grant_idx_nxt = w_win_idx;
          w_beat_cnt_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (w_term) begin
          w_ptr_nxt      = w_ptr_inc;
          w_beat_cnt_nxt = '0;
          if (w_win_found) begin
            w_grant_vec_nxt = PORTS'(1) << w_win_idx;
            w_grant_idx_nxt = w_win_idx;
          end else begin
            w_state_nxt     = S_IDLE;
            w_grant_vec_nxt = '0;
            w_grant_idx_nxt = '0;
          end
        end else if (i_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_grant_vec_nxt = '0;
        w_grant_idx_nxt = '0;
        w_beat_cnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_grant_vec <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_vec <= w_grant_vec_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ptr       <= w_ptr_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
    end
  end

  assign o_grant_vec   = r_grant_vec;
  assign o_grant_valid = |r_grant_vec;
  assign o_grant_idx   = r_grant_idx;
  assign o_beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an owner/pointer model.
module tb_burst_rr_scheduler;

  localparam int P  = 4;
  localparam int MB = 8;
  localparam int IW = $clog2(P);
  localparam int CW = $clog2(MB + 1);

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [P-1:0]  req  = '0;
  logic [P-1:0]  last = '0;
  logic          beat = 1'b0;
  logic [P-1:0]  gvec;
  logic          gval;
  logic [IW-1:0] gidx;
  logic [CW-1:0] bcnt;

  int errors = 0;
  int checks = 0;

  // Model: owner index (-1 = none), rotation pointer, beats in current grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  burst_rr_scheduler #(.PORTS(P), .MAX_BURST(MB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_vec    (req),
    .i_last_vec   (last),
    .i_beat       (beat),
    .o_grant_vec  (gvec),
    .o_grant_valid(gval),
    .o_grant_idx  (gidx),
    .o_beat_cnt   (bcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [P-1:0] r, input int from);
    for (int k = 0; k < P; k++) begin
      int p = (from + k) % P;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic void model_step();
    bit term;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      if (req != '0) begin
        m_owner = search(req, m_ptr);
        m_cnt   = 0;
      end
    end else begin
      term = (beat && (last[m_owner] || m_cnt == MB - 1)) || (!req[m_owner] && !beat);
      if (term) begin
        m_ptr   = (m_owner + 1) % P;
        m_cnt   = 0;
        m_owner = search(req, m_ptr);
      end else if (beat) begin
        m_cnt++;
      end
    end
  endfunction

  // Single compare process: model advances on each edge, outputs checked 1ns later.
  always @(posedge clk) begin
    int exp_vec;
    model_step();
    #1;
    exp_vec = (m_owner < 0) ? 0 : (1 << m_owner);
    chk("model_grant_vec", int'(gvec), exp_vec);
    chk("model_grant_valid", int'(gval), (m_owner < 0) ? 0 : 1);
    chk("model_grant_idx", int'(gidx), (m_owner < 0) ? 0 : m_owner);
    chk("model_beat_cnt", int'(bcnt), m_cnt);
  end

  task automatic cyc(input logic r, input logic [P-1:0] q, input logic [P-1:0] l,
                     input logic b);
    @(negedge clk);
    rst = r; req = q; last = l; beat = b;
    @(posedge clk);
    #2;
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic expect_state(input string tag, input int vec, input int idx,
                              input int cnt);
    chk({tag, "_vec"}, int'(gvec), vec);
    chk({tag, "_valid"}, int'(gval), (vec != 0) ? 1 : 0);
    chk({tag, "_idx"}, int'(gidx), idx);
    chk({tag, "_cnt"}, int'(bcnt), cnt);
    chk({tag, "_model_owner"}, m_owner, (vec == 0) ? -1 : idx);
  endtask

  initial begin
    logic [P-1:0] rq;

    // Reset held with all requests high
    repeat (3) cyc(1'b1, 4'b1111, 4'b0000, 1'b0);
    expect_state("reset", 0, 0, 0);
    cyc(1'b0, 4'b1111, 4'b0000, 1'b0);
    expect_state("reset_release", 4'b0001, 0, 0);
    cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
    expect_state("abort_to_idle", 0, 0, 0);

    // Single burst with last on third beat, then regrant, then drop at last
    cyc(1'b0, 4'b0100, 4'b0000, 1'b0);
    expect_state("single_grant", 4'b0100, 2, 0);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1);
    expect_state("single_b1", 4'b0100, 2, 1);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1);
    expect_state("single_b2", 4'b0100, 2, 2);
    cyc(1'b0, 4'b0100, 4'b0100, 1'b1);
    expect_state("single_regrant", 4'b0100, 2, 0);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0100, 4'b0000, 1'b1);
    expect_state("single2_b2", 4'b0100, 2, 2);
    cyc(1'b0, 4'b0000, 4'b0100, 1'b1);
    expect_state("single_drop_last", 0, 0, 0);

    // Burst cap: two requesters alternate every MB beats without a gap
    cyc(1'b0, 4'b0011, 4'b0000, 1'b0);
    for (int i = 0; i < MB; i++) begin
      expect_state("cap_p0", 4'b0001, 0, i);
      cyc(1'b0, 4'b0011, 4'b0000, 1'b1);
    end
    for (int i = 0; i < MB; i++) begin
      expect_state("cap_p1", 4'b0010, 1, i);
      cyc(1'b0, 4'b0011, 4'b0000, 1'b1);
    end
    expect_state("cap_back_p0", 4'b0001, 0, 0);

    // Fair rotation with last on every beat
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1111, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_state("rotate", 1 << (i % P), i % P, 0);
      cyc(1'b0, 4'b1111, 4'b1111, 1'b1);
    end
    expect_state("rotate_end", 4'b0010, 1, 0);

    // Abort by request drop, then beats in IDLE are ignored
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1010, 4'b0000, 1'b0);
    expect_state("abort_grant", 4'b0010, 1, 0);
    cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
    expect_state("abort_handoff", 4'b1000, 3, 0);
    cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
    expect_state("abort_idle", 0, 0, 0);
    cyc(1'b0, 4'b0000, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 4'b1111, 1'b1);
    expect_state("idle_beat", 0, 0, 0);

    // Reset in the middle of a burst
    cyc(1'b0, 4'b0100, 4'b0000, 1'b0);
    repeat (5) cyc(1'b0, 4'b0100, 4'b0000, 1'b1);
    expect_state("midburst", 4'b0100, 2, 5);
    cyc(1'b1, 4'b0100, 4'b0000, 1'b1);
    expect_state("midburst_reset", 0, 0, 0);
    cyc(1'b0, 4'b1100, 4'b0000, 1'b0);
    expect_state("post_reset_grant", 4'b0100, 2, 0);

    // Randomized traffic; requests are sticky to form realistic bursts
    rq = 4'b0101;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = P'($urandom_range(0, (1 << P) - 1));
      cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
          rq,
          ($urandom_range(0, 3) == 0) ? P'($urandom_range(0, (1 << P) - 1)) : '0,
          ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    cyc(1'b1, 4'b0000, 4'b0000, 1'b0);
    expect_state("final_reset", 0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
